// File: rtl/rca_slice_sequencer.sv
// Multi-cycle wide adder: one shared SLICE_W-bit ripple-carry slice, one slice per clock, LSB first.
// Optional subtract mode is enabled by defining RCA_SEQ_SUB_EN (adds the 'sub' input port).

module rca_fa_cell (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice_sequencer #(
   parameter int SLICE_W    = 4,
   parameter int NUM_SLICES = 4,
   parameter int W          = SLICE_W * NUM_SLICES
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   input  logic         cin,
`ifdef RCA_SEQ_SUB_EN
   input  logic         sub,
`endif
   output logic         ready,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] S,
   output logic         C
);
   localparam int IDX_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_SLICES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [W-1:0]       a_q, a_d, b_q, b_d;
   logic [W-1:0]       wsum_q, wsum_d;
   logic [W-1:0]       s_q, s_d;
   logic               c_q, c_d;

   logic               accept;
   logic [SLICE_W-1:0] sl_a, sl_b, part;
   logic [SLICE_W:0]   cy;

   // Shared slice: operands are muxed out of the working registers by idx.
   assign sl_a  = a_q[int'(idx_q)*SLICE_W +: SLICE_W];
   assign sl_b  = b_q[int'(idx_q)*SLICE_W +: SLICE_W];
   assign cy[0] = carry_q;

   for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
      rca_fa_cell u_fa (
         .a  (sl_a[i]),
         .b  (sl_b[i]),
         .ci (cy[i]),
         .s  (part[i]),
         .co (cy[i+1])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (idx_q == LAST) state_d = DONE;
         DONE:    state_d = accept ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      ready = (state_q == IDLE) || (state_q == DONE);
      busy  = (state_q == RUN);
      done  = (state_q == DONE);
   end

   assign accept = start & ready;

   always_comb begin
      a_d     = a_q;
      b_d     = b_q;
      carry_d = carry_q;
      idx_d   = idx_q;
      wsum_d  = wsum_q;
      s_d     = s_q;
      c_d     = c_q;
      if (accept) begin
         a_d     = A;
         b_d     = B;
         carry_d = cin;
         idx_d   = '0;
`ifdef RCA_SEQ_SUB_EN
         // Two's-complement subtract: invert B once at latch time, force carry-in.
         if (sub) begin
            b_d     = ~B;
            carry_d = 1'b1;
         end
`endif
      end else if (state_q == RUN) begin
         wsum_d[int'(idx_q)*SLICE_W +: SLICE_W] = part;
         carry_d = cy[SLICE_W];
         idx_d   = idx_q + 1'b1;
         if (idx_q == LAST) begin
            s_d   = wsum_d;
            c_d   = cy[SLICE_W];
            idx_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         idx_q   <= '0;
         wsum_q  <= '0;
         s_q     <= '0;
         c_q     <= 1'b0;
      end else begin
         a_q     <= a_d;
         b_q     <= b_d;
         carry_q <= carry_d;
         idx_q   <= idx_d;
         wsum_q  <= wsum_d;
         s_q     <= s_d;
         c_q     <= c_d;
      end
   end

   assign S = s_q;
   assign C = c_q;

endmodule

// File: tb/tb_rca_slice_sequencer.sv
// Randomized + directed bench for rca_slice_sequencer against an arithmetic reference model.
// Subtract cases are exercised only when RCA_SEQ_SUB_EN is defined.

module tb_rca_slice_sequencer;
   localparam int SW = 4;
   localparam int NS = 4;
   localparam int W  = SW * NS;

   logic         clk = 1'b0;
   logic         rst, start, cin, sb;
   logic [W-1:0] A, B, S;
   logic         ready, busy, done, C;

   int           n_chk = 0;
   int           n_fail = 0;
   logic [W-1:0] last_s;
   logic         last_c;

   always #5 clk = ~clk;

   rca_slice_sequencer #(.SLICE_W(SW), .NUM_SLICES(NS)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .A     (A),
      .B     (B),
      .cin   (cin),
`ifdef RCA_SEQ_SUB_EN
      .sub   (sb),
`endif
      .ready (ready),
      .busy  (busy),
      .done  (done),
      .S     (S),
      .C     (C)
   );

   task automatic tb_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference: W-bit result plus carry/no-borrow flag, from plain integer arithmetic.
   function automatic logic [W:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic ci, input logic s);
      longint unsigned ua, ub, r;
      ua = a;
      ub = b;
      if (s) begin
         r = (ua - ub) & ((64'd1 << W) - 1);
         return {(ua >= ub), r[W-1:0]};
      end
      r = ua + ub + longint'(ci);
      return r[W:0];
   endfunction

   // Caller is at a point where ready is high; returns #1 after the accept edge.
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic ci, input logic s);
      A = a; B = b; cin = ci; sb = s; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      A = W'($urandom); B = W'($urandom); cin = 1'($urandom); sb = 1'($urandom);
   endtask

   // Walks the NS RUN cycles and the DONE cycle; ends at the DONE negedge.
   task automatic wait_done(input string tag, input logic [W:0] exp, input logic glitch);
      for (int i = 1; i <= NS; i++) begin
         @(negedge clk);
         tb_chk({tag, ".busy"}, busy, 1);
         tb_chk({tag, ".done_early"}, done, 0);
         tb_chk({tag, ".ready_run"}, ready, 0);
         tb_chk({tag, ".s_hold"}, S, last_s);
         tb_chk({tag, ".c_hold"}, C, last_c);
         if (glitch && i == 1) begin
            A = 16'hAAAA; B = 16'hFFFF; cin = 1'b1; start = 1'b1;
         end
         if (glitch && i == 2) start = 1'b0;
      end
      @(negedge clk);
      tb_chk({tag, ".done"}, done, 1);
      tb_chk({tag, ".ready_done"}, ready, 1);
      tb_chk({tag, ".S"}, S, exp[W-1:0]);
      tb_chk({tag, ".C"}, C, exp[W]);
      last_s = exp[W-1:0];
      last_c = exp[W];
   endtask

   initial begin
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      rst = 1'b1; start = 1'b0; A = '0; B = '0; cin = 1'b0; sb = 1'b0;
      last_s = '0; last_c = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      tb_chk("rst.S", S, 0);
      tb_chk("rst.C", C, 0);
      tb_chk("rst.done", done, 0);
      tb_chk("rst.ready", ready, 1);
      tb_chk("rst.busy", busy, 0);
      rst = 1'b0;
      @(negedge clk);

      start_op(16'h1234, 16'h4321, 1'b0, 1'b0);
      wait_done("t2", ref_op(16'h1234, 16'h4321, 1'b0, 1'b0), 1'b0);
      tb_chk("t2.const", {15'd0, C, S}, 32'h0_5555);

      // New op accepted in the DONE cycle of the previous one.
      start_op(16'h00FF, 16'h0001, 1'b1, 1'b0);
      wait_done("t5", ref_op(16'h00FF, 16'h0001, 1'b1, 1'b0), 1'b0);
      tb_chk("t5.const", {15'd0, C, S}, 32'h0_0101);

      @(posedge clk); #1;
      tb_chk("idle.ready", ready, 1);
      tb_chk("idle.done", done, 0);

      start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      wait_done("t3", ref_op(16'hFFFF, 16'h0001, 1'b0, 1'b0), 1'b0);
      tb_chk("t3.const", {15'd0, C, S}, 32'h1_0000);

      start_op(16'h0001, 16'h0001, 1'b0, 1'b0);
      wait_done("t4", ref_op(16'h0001, 16'h0001, 1'b0, 1'b0), 1'b1);
      tb_chk("t4.const", {15'd0, C, S}, 32'h0_0002);

      // Reset during the second RUN cycle drops the op.
      start_op(16'hBEEF, 16'h1111, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      tb_chk("t6.busy", busy, 1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      last_s = '0; last_c = 1'b0;
      for (int i = 0; i < NS + 2; i++) begin
         @(negedge clk);
         tb_chk("t6.ready", ready, 1);
         tb_chk("t6.busy", busy, 0);
         tb_chk("t6.done", done, 0);
         tb_chk("t6.S", S, 0);
         tb_chk("t6.C", C, 0);
      end

`ifdef RCA_SEQ_SUB_EN
      start_op(16'h0005, 16'h0007, 1'b1, 1'b1);
      wait_done("sub", ref_op(16'h0005, 16'h0007, 1'b1, 1'b1), 1'b0);
      tb_chk("sub.const", {15'd0, C, S}, 32'h0_FFFE);
      start_op(16'h0007, 16'h0007, 1'b0, 1'b1);
      wait_done("sub_eq", ref_op(16'h0007, 16'h0007, 1'b0, 1'b1), 1'b0);
`endif

      for (int n = 0; n < 40; n++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'b0;
`ifdef RCA_SEQ_SUB_EN
         rs = 1'($urandom);
`endif
         if (n % 5 == 0) rb = ~ra;
         start_op(ra, rb, rc, rs);
         wait_done("rnd", ref_op(ra, rb, rc, rs), 1'($urandom));
         if ($urandom_range(0, 1) == 1) begin
            @(posedge clk); #1;
            tb_chk("rnd.idle", {busy, done, ready}, 3'b001);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
